// File: rtl/cpu_pkg.sv
// Shared definitions for the MEM-stage data-memory arbiter: FSM encoding and
// the default peripheral starvation limit.
package cpu_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_CPU  = 2'd1,
        ARB_PERI = 2'd2
    } arb_state_t;

    localparam int unsigned DEF_MAX_STARVE = 4;
    localparam int          STARVE_W       = 4;

    function automatic logic [STARVE_W-1:0] sat_inc(input logic [STARVE_W-1:0] v);
        return (v == {STARVE_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/dmem_arbiter.sv
// Single-port data memory sequencer: arbitrates the MEM-stage access against one
// peripheral/DMA requester, runs variable-latency handshakes and drives the pipeline stall.
module dmem_arbiter
    import cpu_pkg::*;
#(
    parameter int unsigned MAX_STARVE = DEF_MAX_STARVE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRd_EX_MEM,
    input  logic        MemWr_EX_MEM,
    input  logic [31:0] ALUOut_EX_MEM,
    input  logic [31:0] DatabusB_EX_MEM,
    output logic [31:0] cpu_rdata,
    output logic        stall,
    input  logic        peri_req,
    input  logic        peri_we,
    input  logic [31:0] peri_addr,
    input  logic [31:0] peri_wdata,
    output logic        peri_gnt,
    output logic        peri_done,
    output logic [31:0] peri_rdata,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    localparam logic [STARVE_W-1:0] C_MAX_STARVE = STARVE_W'(MAX_STARVE);

    arb_state_t          r_state;
    logic [STARVE_W-1:0] r_starve_cnt;
    logic                r_mem_rd;
    logic                r_mem_wr;
    logic [31:0]         r_mem_addr;
    logic [31:0]         r_mem_wdata;
    logic [31:0]         r_peri_rdata;
    logic                r_peri_done;

    logic w_cpu_req;
    logic w_peri_wins;

    assign w_cpu_req   = MemRd_EX_MEM | MemWr_EX_MEM;
    // Peripheral wins when uncontested, or when the CPU has had its quota of contested grants.
    assign w_peri_wins = peri_req & (~w_cpu_req | (r_starve_cnt >= C_MAX_STARVE));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ARB_IDLE;
            r_starve_cnt <= '0;
            r_mem_rd     <= 1'b0;
            r_mem_wr     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_peri_rdata <= '0;
            r_peri_done  <= 1'b0;
        end else begin
            r_peri_done <= 1'b0;
            if (!peri_req) begin
                r_starve_cnt <= '0;
            end

            case (r_state)
                ARB_IDLE: begin
                    if (w_peri_wins) begin
                        r_state      <= ARB_PERI;
                        r_mem_rd     <= ~peri_we;
                        r_mem_wr     <= peri_we;
                        r_mem_addr   <= peri_addr;
                        r_mem_wdata  <= peri_wdata;
                        r_starve_cnt <= '0;
                    end else if (w_cpu_req) begin
                        r_state     <= ARB_CPU;
                        r_mem_rd    <= MemRd_EX_MEM;
                        r_mem_wr    <= MemWr_EX_MEM;
                        r_mem_addr  <= ALUOut_EX_MEM;
                        r_mem_wdata <= DatabusB_EX_MEM;
                        if (peri_req) begin
                            r_starve_cnt <= sat_inc(r_starve_cnt);
                        end
                    end
                end

                ARB_CPU: begin
                    if (mem_ready) begin
                        r_state     <= ARB_IDLE;
                        r_mem_rd    <= 1'b0;
                        r_mem_wr    <= 1'b0;
                        r_mem_addr  <= '0;
                        r_mem_wdata <= '0;
                    end
                end

                ARB_PERI: begin
                    if (mem_ready) begin
                        r_state     <= ARB_IDLE;
                        r_mem_rd    <= 1'b0;
                        r_mem_wr    <= 1'b0;
                        r_mem_addr  <= '0;
                        r_mem_wdata <= '0;
                        r_peri_done <= 1'b1;
                        if (r_mem_rd) begin
                            r_peri_rdata <= mem_rdata;
                        end
                    end
                end

                default: begin
                    r_state <= ARB_IDLE;
                end
            endcase
        end
    end

    // Combinational so the pipeline unfreezes and MEM/WB captures load data on the completing edge.
    assign stall     = w_cpu_req & ~((r_state == ARB_CPU) & mem_ready);
    assign cpu_rdata = (r_state == ARB_CPU) ? mem_rdata : 32'h0;

    assign peri_gnt   = (r_state == ARB_PERI);
    assign peri_done  = r_peri_done;
    assign peri_rdata = r_peri_rdata;
    assign mem_rd     = r_mem_rd;
    assign mem_wr     = r_mem_wr;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed CPU/peripheral traffic against a
// wait-state memory responder; expected transactions are queued in grant order.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRd_EX_MEM, MemWr_EX_MEM;
    logic [31:0] ALUOut_EX_MEM, DatabusB_EX_MEM;
    logic [31:0] cpu_rdata;
    logic        stall;
    logic        peri_req, peri_we;
    logic [31:0] peri_addr, peri_wdata;
    logic        peri_gnt, peri_done;
    logic [31:0] peri_rdata;
    logic        mem_rd, mem_wr;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ready;

    always #5 clk = ~clk;

    dmem_arbiter #(.MAX_STARVE(2)) dut (
        .clk             (clk),
        .reset           (reset),
        .MemRd_EX_MEM    (MemRd_EX_MEM),
        .MemWr_EX_MEM    (MemWr_EX_MEM),
        .ALUOut_EX_MEM   (ALUOut_EX_MEM),
        .DatabusB_EX_MEM (DatabusB_EX_MEM),
        .cpu_rdata       (cpu_rdata),
        .stall           (stall),
        .peri_req        (peri_req),
        .peri_we         (peri_we),
        .peri_addr       (peri_addr),
        .peri_wdata      (peri_wdata),
        .peri_gnt        (peri_gnt),
        .peri_done       (peri_done),
        .peri_rdata      (peri_rdata),
        .mem_rd          (mem_rd),
        .mem_wr          (mem_wr),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .mem_ready       (mem_ready)
    );

    typedef struct {
        bit          is_peri;
        bit          we;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    txn_t        exp_q[$];
    logic [31:0] done_q[$];
    txn_t        mon_t;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          wait_states = 0;
    int          resp_wcnt   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end else begin
            $display("ok   %s: %h (t=%0t)", name, act, $time);
        end
    endtask

    function automatic logic [31:0] rd_value(input logic [31:0] a);
        return (a == 32'h0000_0100) ? 32'hDEAD_BEEF : (a ^ 32'h5A5A_5A5A);
    endfunction

    // Memory responder: asserts ready after wait_states strobe cycles.
    initial begin
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_rd || mem_wr) begin
                mem_ready = (resp_wcnt >= wait_states);
                resp_wcnt = mem_ready ? 0 : resp_wcnt + 1;
                mem_rdata = mem_rd ? rd_value(mem_addr) : 32'h0;
            end else begin
                mem_ready = 1'b0;
                resp_wcnt = 0;
                mem_rdata = 32'h0;
            end
        end
    end

    // Monitor: every completing memory cycle and every peri_done pulse pops the scoreboard.
    always @(negedge clk) begin
        if (reset && (mem_rd || mem_wr) && mem_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_txn_addr", mem_addr, 32'hFFFF_FFFF);
            end else begin
                mon_t = exp_q.pop_front();
                chk("grant_src", {31'h0, peri_gnt}, {31'h0, mon_t.is_peri});
                chk("txn_we", {31'h0, mem_wr}, {31'h0, mon_t.we});
                chk("txn_addr", mem_addr, mon_t.addr);
                if (mon_t.we) begin
                    chk("txn_wdata", mem_wdata, mon_t.data);
                end else if (!mon_t.is_peri) begin
                    chk("cpu_rdata", cpu_rdata, mon_t.data);
                end else begin
                    done_q.push_back(mon_t.data);
                end
                if (!mon_t.is_peri) begin
                    chk("stall_on_ready", {31'h0, stall}, 32'h0);
                end
            end
        end
        if (reset && peri_done) begin
            if (done_q.size() == 0) begin
                chk("unexpected_peri_done", peri_rdata, 32'hFFFF_FFFF);
            end else begin
                chk("peri_rdata", peri_rdata, done_q.pop_front());
            end
        end
    end

    task automatic cpu_access(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                              output int stall_cyc, output int total, output int strobe_cyc);
        @(posedge clk);
        #1;
        MemRd_EX_MEM    = !we;
        MemWr_EX_MEM    = we;
        ALUOut_EX_MEM   = addr;
        DatabusB_EX_MEM = wdata;
        stall_cyc  = 0;
        total      = 0;
        strobe_cyc = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            total++;
            if ((mem_rd || mem_wr) && mem_addr == addr && mem_wr == we && (!we || mem_wdata == wdata))
                strobe_cyc++;
            if (!stall) break;
            stall_cyc++;
        end
        chk("cpu_done_in_budget", {31'h0, stall}, 32'h0);
    endtask

    task automatic cpu_idle();
        @(posedge clk);
        #1;
        MemRd_EX_MEM = 1'b0;
        MemWr_EX_MEM = 1'b0;
    endtask

    // Caller aligns the first call to posedge+1; keep=1 leaves peri_req high for a follow-on request.
    task automatic peri_access(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                               input bit keep, output int lat, output int gnt_cyc);
        peri_req   = 1'b1;
        peri_we    = we;
        peri_addr  = addr;
        peri_wdata = wdata;
        lat     = 0;
        gnt_cyc = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (peri_gnt) gnt_cyc++;
            if (peri_done) break;
            lat++;
        end
        chk("peri_done_in_budget", {31'h0, peri_done}, 32'h1);
        if (!keep) peri_req = 1'b0;
    endtask

    function automatic txn_t mk(input bit p, input bit w, input logic [31:0] a, input logic [31:0] d);
        txn_t t;
        t.is_peri = p;
        t.we      = w;
        t.addr    = a;
        t.data    = d;
        return t;
    endfunction

    int sc, tot, stb, lat, gnt, lat2, gnt2, done_seen;

    initial begin
        reset = 1'b0;
        MemRd_EX_MEM = 1'b1; MemWr_EX_MEM = 1'b0;
        ALUOut_EX_MEM = 32'h0; DatabusB_EX_MEM = 32'h0;
        peri_req = 1'b0; peri_we = 1'b0; peri_addr = 32'h0; peri_wdata = 32'h0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_stall_with_req", {31'h0, stall}, 32'h1);
        MemRd_EX_MEM = 1'b0;
        #1;
        chk("rst_stall_no_req", {31'h0, stall}, 32'h0);
        chk("rst_flags", {28'h0, mem_rd, mem_wr, peri_gnt, peri_done}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_peri_rdata", peri_rdata, 32'h0);
        chk("rst_cpu_rdata", cpu_rdata, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // Zero-wait CPU load
        exp_q.push_back(mk(0, 0, 32'h0000_0010, 32'h5A5A_5A4A));
        cpu_access(0, 32'h0000_0010, 32'h0, sc, tot, stb);
        cpu_idle();
        chk("load_stall_cycles", sc, 1);
        chk("load_total_cycles", tot, 2);

        // CPU store, 3 wait states
        wait_states = 3;
        exp_q.push_back(mk(0, 1, 32'h0000_0020, 32'hCAFE_F00D));
        cpu_access(1, 32'h0000_0020, 32'hCAFE_F00D, sc, tot, stb);
        cpu_idle();
        chk("store_stall_cycles", sc, 4);
        chk("store_total_cycles", tot, 5);
        chk("store_strobe_stable", stb, 4);
        wait_states = 0;

        // Peripheral read with CPU load arriving mid-access
        exp_q.push_back(mk(1, 0, 32'h0000_0100, 32'hDEAD_BEEF));
        exp_q.push_back(mk(0, 0, 32'h0000_0030, 32'h5A5A_5A6A));
        fork
            begin
                @(posedge clk); #1;
                peri_access(0, 32'h0000_0100, 32'h0, 0, lat, gnt);
            end
            begin
                @(posedge clk);
                cpu_access(0, 32'h0000_0030, 32'h0, sc, tot, stb);
                cpu_idle();
            end
        join
        chk("peri_gnt_cycles", gnt, 1);
        chk("peri_latency_n0", lat, 2);
        chk("cpu_behind_peri_stall", sc, 2);

        // Peripheral read with 2 wait states
        wait_states = 2;
        exp_q.push_back(mk(1, 0, 32'h0000_0028, 32'h5A5A_5A72));
        @(posedge clk); #1;
        peri_access(0, 32'h0000_0028, 32'h0, 0, lat, gnt);
        chk("peri_latency_n2", lat, 4);
        chk("peri_gnt_cycles_n2", gnt, 3);
        wait_states = 0;

        // Simultaneous arrival: CPU first, peripheral on the next idle cycle
        exp_q.push_back(mk(0, 0, 32'h0000_0024, 32'h5A5A_5A7E));
        exp_q.push_back(mk(1, 0, 32'h0000_0200, 32'h5A5A_585A));
        fork
            begin
                cpu_access(0, 32'h0000_0024, 32'h0, sc, tot, stb);
                cpu_idle();
            end
            begin
                @(posedge clk); #1;
                peri_access(0, 32'h0000_0200, 32'h0, 0, lat, gnt);
            end
        join
        chk("simul_cpu_stall", sc, 1);
        chk("simul_peri_latency", lat, 4);

        // Continuous contention with MAX_STARVE=2: C C P C C P
        exp_q.push_back(mk(0, 0, 32'h0000_0040, 32'h5A5A_5A1A));
        exp_q.push_back(mk(0, 0, 32'h0000_0044, 32'h5A5A_5A1E));
        exp_q.push_back(mk(1, 0, 32'h0000_0080, 32'h5A5A_5ADA));
        exp_q.push_back(mk(0, 1, 32'h0000_0048, 32'h1111_1111));
        exp_q.push_back(mk(0, 0, 32'h0000_004C, 32'h5A5A_5A16));
        exp_q.push_back(mk(1, 0, 32'h0000_0100, 32'hDEAD_BEEF));
        fork
            begin
                cpu_access(0, 32'h0000_0040, 32'h0, sc, tot, stb);
                cpu_access(0, 32'h0000_0044, 32'h0, sc, tot, stb);
                cpu_access(1, 32'h0000_0048, 32'h1111_1111, sc, tot, stb);
                cpu_access(0, 32'h0000_004C, 32'h0, sc, tot, stb);
                cpu_idle();
            end
            begin
                @(posedge clk); #1;
                peri_access(0, 32'h0000_0080, 32'h0, 1, lat, gnt);
                peri_access(0, 32'h0000_0100, 32'h0, 0, lat2, gnt2);
            end
        join
        chk("contention_q_drained", exp_q.size(), 0);

        // Asynchronous reset during a stalled peripheral access
        wait_states = 1000;
        @(posedge clk); #1;
        peri_req = 1'b1; peri_we = 1'b0; peri_addr = 32'h0000_0300;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_peri_gnt", {31'h0, peri_gnt}, 32'h1);
        chk("pre_rst_mem_rd", {31'h0, mem_rd}, 32'h1);
        #1;
        reset = 1'b0;
        #1;
        chk("async_rst_mem_rd", {31'h0, mem_rd}, 32'h0);
        chk("async_rst_peri_gnt", {31'h0, peri_gnt}, 32'h0);
        peri_req = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (peri_done) done_seen++;
        end
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (peri_done) done_seen++;
        end
        chk("no_done_after_rst", done_seen, 0);
        chk("starve_cnt_after_rst", {28'h0, dut.r_starve_cnt}, 32'h0);
        chk("idle_after_rst", {30'h0, mem_rd, mem_wr}, 32'h0);
        wait_states = 0;

        chk("exp_q_empty", exp_q.size(), 0);
        chk("done_q_empty", done_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit at t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
